// File: rtl/c2q_pkg.sv
// c2q_pkg: FSM states, default command record and sizing helper shared by the C2 request queue.
package c2q_pkg;

    typedef enum logic [1:0] {
        WAIT_RST,
        IDLE,
        REQ,
        RDDATA
    } c2q_state_t;

    // Record at the default 4-bit address / 8-bit data widths; the top rebuilds it at its own widths.
    typedef struct packed {
        logic       rd_not_write;
        logic [3:0] addr;
        logic [7:0] wrdata;
    } c2q_cmd_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/c2q_fifo.sv
// c2q_fifo: synchronous command FIFO with registered count; DEPTH must be a power of two.
module c2q_fifo
    import c2q_pkg::*;
#(
    parameter type T = c2q_cmd_t,
    parameter int DEPTH = 4,
    localparam int CW = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    T mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/c2_request_queue.sv
// c2_request_queue: buffers master commands and issues them one at a time on the arbiter C2 port.
// Define C2Q_TIMEOUT_EN to abort requests left unacknowledged for G_TIMEOUT cycles (adds TIMEOUT_ERR).
module c2_request_queue
    import c2q_pkg::*;
#(
    parameter int G_ADDR_WIDTH      = 4,
    parameter int G_DATA_WIDTH      = 8,
    parameter int G_REGISTERED_DATA = 0,
    parameter int G_FIFO_DEPTH      = 4,
    parameter int G_TIMEOUT         = 15
) (
    input  logic                    CLOCK,
    input  logic                    RST,
    input  logic                    RST_DONE,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_RD_NOT_WRITE,
    input  logic [G_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [G_DATA_WIDTH-1:0] CMD_WRDATA,
    output logic                    REQUEST_C2,
    output logic                    RD_NOT_WRITE_C2,
    output logic [G_ADDR_WIDTH-1:0] ADDR_C2,
    output logic [G_DATA_WIDTH-1:0] DATAIN_C2,
    input  logic                    ACK_C2,
    input  logic [G_DATA_WIDTH-1:0] DATAOUT_C2,
    output logic                    RSP_VALID,
    output logic [G_DATA_WIDTH-1:0] RSP_DATA,
    output logic [G_ADDR_WIDTH-1:0] RSP_ADDR,
    output logic                    WR_DONE,
`ifdef C2Q_TIMEOUT_EN
    output logic                    TIMEOUT_ERR,
`endif
    output logic                    BUSY
);

    localparam int CW = count_width(G_FIFO_DEPTH);

    typedef struct packed {
        logic                    rd_not_write;
        logic [G_ADDR_WIDTH-1:0] addr;
        logic [G_DATA_WIDTH-1:0] wrdata;
    } cmd_t;

    if (G_FIFO_DEPTH < 2 || (G_FIFO_DEPTH & (G_FIFO_DEPTH - 1)) != 0 || G_TIMEOUT < 1) begin : g_bad_params
        $error("c2_request_queue: G_FIFO_DEPTH must be a power of two >= 2 and G_TIMEOUT >= 1");
    end

    c2q_state_t    state;
    c2q_state_t    state_n;
    cmd_t          cmd;
    cmd_t          head;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          ack_req;
    logic          rsp_load;
    logic          tmo;
    logic [CW-1:0] count;

    assign cmd       = {CMD_RD_NOT_WRITE, CMD_ADDR, CMD_WRDATA};
    assign CMD_READY = !full && !RST;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = state == IDLE && !empty;
    assign ack_req   = state == REQ && ACK_C2;
    assign rsp_load  = state == RDDATA || (ack_req && RD_NOT_WRITE_C2 && G_REGISTERED_DATA == 0);
    assign BUSY      = count != '0 || (state != IDLE && state != WAIT_RST);

    c2q_fifo #(
        .T     (cmd_t),
        .DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (cmd),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef C2Q_TIMEOUT_EN
    localparam int TW = $clog2(G_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    // An ACK in the terminal-count cycle takes priority over the abort.
    assign tmo = state == REQ && !ACK_C2 && tcnt == TW'(G_TIMEOUT - 1);
    always_ff @(posedge CLOCK) begin
        tcnt        <= (RST || state != REQ) ? '0 : tcnt + TW'(1);
        TIMEOUT_ERR <= !RST && tmo;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        state <= RST ? WAIT_RST : state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            WAIT_RST: state_n = RST_DONE ? IDLE : WAIT_RST;
            IDLE:     state_n = empty ? IDLE : REQ;
            REQ:      state_n = ACK_C2 ? ((RD_NOT_WRITE_C2 && G_REGISTERED_DATA != 0) ? RDDATA : IDLE)
                                       : (tmo ? IDLE : REQ);
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            REQUEST_C2      <= 1'b0;
            RD_NOT_WRITE_C2 <= 1'b0;
            ADDR_C2         <= '0;
            DATAIN_C2       <= '0;
            RSP_VALID       <= 1'b0;
            RSP_DATA        <= '0;
            RSP_ADDR        <= '0;
            WR_DONE         <= 1'b0;
        end else begin
            RSP_VALID <= rsp_load;
            WR_DONE   <= ack_req && !RD_NOT_WRITE_C2;
            if (pop) begin
                REQUEST_C2      <= 1'b1;
                RD_NOT_WRITE_C2 <= head.rd_not_write;
                ADDR_C2         <= head.addr;
                DATAIN_C2       <= head.wrdata;
            end else if (ack_req || tmo) begin
                REQUEST_C2 <= 1'b0;
            end
            if (rsp_load) begin
                RSP_DATA <= DATAOUT_C2;
                RSP_ADDR <= ADDR_C2;
            end
        end
    end

endmodule
